// File: rtl/icache_axi_refill_pkg.sv
// Shared constants and state encoding for the icache AXI refill engine.
// AXI read-channel encodings and the active-low reset level.
package icache_axi_refill_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic       RST_ENABLE     = 1'b0;

    localparam int LINE_WORDS = 16;
    localparam int LINE_BITS  = 512;

    typedef enum logic [1:0] {
        RF_IDLE = 2'b00,
        RF_AR   = 2'b01,
        RF_R    = 2'b10,
        RF_DONE = 2'b11
    } rf_state_e;

endpackage

// File: rtl/icache_axi_refill.sv
// Refill engine: one icache line miss becomes one AXI INCR read burst.
// Beats are gathered into a 512-bit line, word k at [511-32k -: 32].
module icache_axi_refill
    import icache_axi_refill_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic [31:0]  addr,
    input  logic [3:0]   burst,
    output logic         addr_ok,
    output logic         data_ok,
    output logic [511:0] line_o,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic [1:0]   arlock,
    output logic [3:0]   arcache,
    output logic [2:0]   arprot,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    rf_state_e   r_state;
    rf_state_e   w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  r_len;
    logic [31:0] r_araddr;
    logic [31:0] r_words [LINE_WORDS];
    logic        w_unused;

    // rid/rresp are deliberately ignored; rlast only feeds the check below.
    assign w_unused = ^{rid, rresp, rlast};

    // State register; reset drops any burst in flight straight to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_state <= RF_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and AXI/handshake outputs, all decoded from the state.
    always_comb begin
        w_next  = r_state;
        arvalid = 1'b0;
        arsize  = 3'b000;
        arburst = 2'b00;
        rready  = 1'b0;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        unique case (r_state)
            RF_IDLE: begin
                if (req) begin
                    w_next = RF_AR;
                end
            end
            RF_AR: begin
                arvalid = 1'b1;
                arsize  = AXI_SIZE_4B;
                arburst = AXI_BURST_INCR;
                addr_ok = arready;
                if (arready) begin
                    w_next = RF_R;
                end
            end
            RF_R: begin
                rready = 1'b1;
                if (rvalid && (r_cnt == r_len)) begin
                    w_next = RF_DONE;
                end
            end
            RF_DONE: begin
                data_ok = 1'b1;
                w_next  = RF_IDLE;
            end
            default: begin
                w_next = RF_IDLE;
            end
        endcase
    end

    // Request latch and beat assembler; the line holds until the next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_cnt    <= 4'd0;
            r_len    <= 4'd0;
            r_araddr <= 32'd0;
            for (int k = 0; k < LINE_WORDS; k++) begin
                r_words[k] <= 32'd0;
            end
        end else if (r_state == RF_IDLE && req) begin
            r_cnt    <= 4'd0;
            r_len    <= burst;
            r_araddr <= addr;
            for (int k = 0; k < LINE_WORDS; k++) begin
                r_words[k] <= 32'd0;
            end
        end else if (r_state == RF_R && rvalid) begin
            r_words[r_cnt] <= rdata;
            r_cnt          <= r_cnt + 4'd1;
        end
    end

    // Pack the word array with beat 0 in the most significant slot.
    always_comb begin
        line_o = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            line_o[LINE_BITS-1-32*k -: 32] = r_words[k];
        end
    end

    assign arid    = AXI_ID;
    assign araddr  = r_araddr;
    assign arlen   = {4'b0000, r_len};
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    property p_rlast_on_final;
        @(posedge clk) disable iff (rst == RST_ENABLE)
        (r_state == RF_R && rvalid) |-> (rlast == (r_cnt == r_len));
    endproperty

    a_rlast_on_final: assert property (p_rlast_on_final);

endmodule
